// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared widths, IO region tag and controller state encoding
package mem_ctrl_pkg;
  localparam int MEM_ADD_W = 18;
  localparam int MEM_DAT_W = 8;
  localparam logic [1:0] IO_TAG_DEF = 2'b11;
  typedef enum logic [1:0] {MC_IDLE, MC_ISSUE, MC_WAIT} mc_state_t;
endpackage

// File: rtl/mc_req_slot.sv
// mc_req_slot: strobe-loaded pending request register with clear
module mc_req_slot
  import mem_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 ld,
  input  logic                 clr,
  input  logic                 ld_rw,
  input  logic [MEM_ADD_W-1:0] ld_add,
  input  logic [MEM_DAT_W-1:0] ld_dat,
  output logic                 valid,
  output logic                 rw,
  output logic [MEM_ADD_W-1:0] add,
  output logic [MEM_DAT_W-1:0] dat
);
  // a new strobe wins over a same-edge clear so a request is never dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      rw    <= 1'b0;
      add   <= '0;
      dat   <= '0;
    end else if (en) begin
      valid <= ld ? 1'b1 : (clr ? 1'b0 : valid);
      rw    <= ld ? ld_rw : rw;
      add   <= ld ? ld_add : add;
      dat   <= ld ? ld_dat : dat;
    end
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial arbiter between data/instruction caches and a byte RAM
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_TAG = IO_TAG_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iDC_En,
  input  logic                 iDC_Rw,
  input  logic [MEM_ADD_W-1:0] iDC_Add,
  input  logic [MEM_DAT_W-1:0] iDC_Dat,
  output logic                 oDC_En,
  output logic [MEM_DAT_W-1:0] oDC_Dat,
  input  logic                 iIC_En,
  input  logic [MEM_ADD_W-1:0] iIC_Add,
  output logic                 oIC_En,
  output logic [MEM_DAT_W-1:0] oIC_Dat,
  input  logic                 iIO_Full,
  input  logic [MEM_DAT_W-1:0] iRAM_Dat,
  output logic [MEM_DAT_W-1:0] oRAM_Dat,
  output logic [MEM_ADD_W-1:0] oRAM_Add,
  output logic                 oRAM_Wr
);
  mc_state_t state, state_nx;
  logic dc_v, dc_rw, ic_v, ic_rw;
  logic [MEM_ADD_W-1:0] dc_add, ic_add;
  logic [MEM_DAT_W-1:0] dc_dat, ic_dat;
  logic blocked, serve_dc, serve_ic, owner_dc, rw_q, wr_q;
  mc_req_slot u_dc (
    .clk(clk), .rst(rst), .en(en), .ld(iDC_En), .clr(serve_dc),
    .ld_rw(iDC_Rw), .ld_add(iDC_Add), .ld_dat(iDC_Dat),
    .valid(dc_v), .rw(dc_rw), .add(dc_add), .dat(dc_dat)
  );
  mc_req_slot u_ic (
    .clk(clk), .rst(rst), .en(en), .ld(iIC_En), .clr(serve_ic),
    .ld_rw(1'b0), .ld_add(iIC_Add), .ld_dat('0),
    .valid(ic_v), .rw(ic_rw), .add(ic_add), .dat(ic_dat)
  );
  // a frozen controller must never hold a write on the bus
  assign oRAM_Wr = wr_q & en;
  // arbitration (DC first unless its IO write is blocked) and next state
  always_comb begin
    blocked  = dc_rw && (dc_add[17:16] == IO_TAG) && iIO_Full;
    serve_dc = (state == MC_IDLE) && dc_v && !blocked;
    serve_ic = (state == MC_IDLE) && !serve_dc && ic_v;
    state_nx = (state == MC_IDLE)  ? ((serve_dc || serve_ic) ? MC_ISSUE : MC_IDLE) :
               (state == MC_ISSUE) ? MC_WAIT : MC_IDLE;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= MC_IDLE;
    else if (en) state <= state_nx;
  end
  // bus drive on grant, read capture and done pulse at the end of WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_dc <= 1'b0;
      rw_q     <= 1'b0;
      wr_q     <= 1'b0;
      oRAM_Add <= '0;
      oRAM_Dat <= '0;
      oDC_En   <= 1'b0;
      oIC_En   <= 1'b0;
      oDC_Dat  <= '0;
      oIC_Dat  <= '0;
    end else if (en) begin
      owner_dc <= (serve_dc || serve_ic) ? serve_dc : owner_dc;
      rw_q     <= serve_dc ? dc_rw : (serve_ic ? ic_rw : rw_q);
      wr_q     <= serve_dc ? dc_rw : (serve_ic ? ic_rw : 1'b0);
      oRAM_Add <= serve_dc ? dc_add : (serve_ic ? ic_add : oRAM_Add);
      oRAM_Dat <= serve_dc ? dc_dat : (serve_ic ? ic_dat : oRAM_Dat);
      oDC_En   <= (state == MC_WAIT) && owner_dc;
      oIC_En   <= (state == MC_WAIT) && !owner_dc;
      oDC_Dat  <= ((state == MC_WAIT) && owner_dc && !rw_q) ? iRAM_Dat : oDC_Dat;
      oIC_Dat  <= ((state == MC_WAIT) && !owner_dc) ? iRAM_Dat : oIC_Dat;
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed and randomized checks of mem_ctrl against a transaction-level model
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst, en, iDC_En, iDC_Rw, iIC_En, iIO_Full, oDC_En, oIC_En, oRAM_Wr;
  logic [MEM_ADD_W-1:0] iDC_Add, iIC_Add, oRAM_Add;
  logic [MEM_DAT_W-1:0] iDC_Dat, oDC_Dat, oIC_Dat, iRAM_Dat, oRAM_Dat;
  int n_chk = 0, n_fail = 0, cyc = 0, n_wr = 0;
  logic [7:0] wmem [int];
  logic [7:0] ref_mem [int];
  int dc_t[$], ic_t[$], wr_t[$];
  logic [7:0] dc_d[$], ic_d[$];
  logic [7:0] dc_last;
  mem_ctrl dut (
    .clk(clk), .rst(rst), .en(en),
    .iDC_En(iDC_En), .iDC_Rw(iDC_Rw), .iDC_Add(iDC_Add), .iDC_Dat(iDC_Dat),
    .oDC_En(oDC_En), .oDC_Dat(oDC_Dat),
    .iIC_En(iIC_En), .iIC_Add(iIC_Add), .oIC_En(oIC_En), .oIC_Dat(oIC_Dat),
    .iIO_Full(iIO_Full), .iRAM_Dat(iRAM_Dat), .oRAM_Dat(oRAM_Dat),
    .oRAM_Add(oRAM_Add), .oRAM_Wr(oRAM_Wr)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] seed(input int a);
    return (a == 32'h100) ? 8'hA5 : 8'((a * 37) ^ (a >> 8) ^ 8'h5C);
  endfunction
  function automatic logic [7:0] ram_rd(input int a);
    return wmem.exists(a) ? wmem[a] : seed(a);
  endfunction
  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : seed(a);
  endfunction
  // byte RAM: read data registered one cycle after the address
  always @(posedge clk) begin
    cyc <= cyc + 1;
    iRAM_Dat <= ram_rd(int'(oRAM_Add));
    if (oRAM_Wr) begin
      wmem[int'(oRAM_Add)] = oRAM_Dat;
      wr_t.push_back(cyc + 1);
      n_wr++;
    end
  end
  // done-pulse monitor, stamped with the edge that raised the pulse
  always @(negedge clk) begin
    if (oDC_En) begin
      dc_t.push_back(cyc);
      dc_d.push_back(oDC_Dat);
    end
    if (oIC_En) begin
      ic_t.push_back(cyc);
      ic_d.push_back(oIC_Dat);
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic waitn(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic clear_q;
    dc_t.delete(); dc_d.delete(); ic_t.delete(); ic_d.delete(); wr_t.delete();
  endtask
  task automatic strobe(input logic dc, input logic rw, input logic [17:0] da, input logic [7:0] dd,
                        input logic ic, input logic [17:0] ia, output int t);
    iDC_En = dc; iDC_Rw = rw; iDC_Add = da; iDC_Dat = dd;
    iIC_En = ic; iIC_Add = ia;
    t = cyc + 1;
    waitn(1);
    iDC_En = 1'b0; iIC_En = 1'b0;
  endtask
  initial begin
    int t, nw0;
    logic dc, ic, rw;
    logic [17:0] da, ia;
    logic [7:0] dd, exp_d;
    rst = 1'b1; en = 1'b1; iDC_En = 1'b0; iDC_Rw = 1'b0; iDC_Add = '0; iDC_Dat = '0;
    iIC_En = 1'b0; iIC_Add = '0; iIO_Full = 1'b0;
    waitn(3);
    check("reset_outs", {oDC_En, oIC_En, oRAM_Wr, oDC_Dat, oIC_Dat, oRAM_Dat, oRAM_Add}, 0);
    rst = 1'b0;
    waitn(1);
    // DC read latency and data
    clear_q();
    strobe(1, 0, 18'h100, 8'h00, 0, 0, t);
    waitn(1);
    check("rd_add", oRAM_Add, 18'h100);
    check("rd_nowr", oRAM_Wr, 0);
    waitn(1);
    check("rd_early", oDC_En, 0);
    waitn(1);
    check("rd_done", oDC_En, 1);
    check("rd_dat", oDC_Dat, 8'hA5);
    waitn(1);
    check("rd_pulse", oDC_En, 0);
    dc_last = 8'hA5;
    // DC write: one-cycle write strobe, data output untouched
    clear_q();
    nw0 = n_wr;
    strobe(1, 1, 18'h200, 8'h3C, 0, 0, t);
    waitn(1);
    check("wr_strobe", oRAM_Wr, 1);
    check("wr_dat", oRAM_Dat, 8'h3C);
    waitn(1);
    check("wr_once", oRAM_Wr, 0);
    waitn(1);
    check("wr_done", oDC_En, 1);
    check("wr_keep", oDC_Dat, dc_last);
    waitn(2);
    check("wr_count", n_wr - nw0, 1);
    check("wr_ram", ram_rd(32'h200), 8'h3C);
    check("wr_no_ic", ic_t.size(), 0);
    ref_mem[32'h200] = 8'h3C;
    // simultaneous strobes: DC first, IC three cycles later
    clear_q();
    strobe(1, 0, 18'h10, 8'h00, 1, 18'h20, t);
    waitn(8);
    check("sim_dc_n", dc_t.size(), 1);
    check("sim_ic_n", ic_t.size(), 1);
    check("sim_dc_t", dc_t[0], t + 3);
    check("sim_ic_t", ic_t[0], t + 6);
    check("sim_dc_d", dc_d[0], ref_rd(32'h10));
    check("sim_ic_d", ic_d[0], ref_rd(32'h20));
    dc_last = ref_rd(32'h10);
    // IO-region write blocked while the IO buffer is full
    clear_q();
    nw0 = n_wr;
    iIO_Full = 1'b1;
    strobe(1, 1, 18'h30000, 8'h5A, 1, 18'h40, t);
    waitn(5);
    check("io_ic_t", ic_t[0], t + 3);
    check("io_ic_d", ic_d[0], ref_rd(32'h40));
    check("io_held", n_wr - nw0, 0);
    iIO_Full = 1'b0;
    waitn(8);
    check("io_wr_n", wr_t.size(), 1);
    check("io_wr_late", wr_t[0] >= t + 7, 1);
    check("io_dc_t", dc_t[0], wr_t[0] + 1);
    check("io_ram", ram_rd(32'h30000), 8'h5A);
    check("io_keep", dc_d[0], dc_last);
    ref_mem[32'h30000] = 8'h5A;
    // freeze during ISSUE of a write
    clear_q();
    nw0 = n_wr;
    strobe(1, 1, 18'h1234, 8'hC7, 0, 0, t);
    waitn(1);
    check("frz_wr", oRAM_Wr, 1);
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      waitn(1);
      check("frz_gate", oRAM_Wr, 0);
    end
    en = 1'b1;
    waitn(4);
    check("frz_count", n_wr - nw0, 1);
    check("frz_dc_n", dc_t.size(), 1);
    check("frz_dc_t", dc_t[0], t + 7);
    check("frz_ram", ram_rd(32'h1234), 8'hC7);
    ref_mem[32'h1234] = 8'hC7;
    // reset while waiting for read data
    clear_q();
    strobe(1, 0, 18'h555, 8'h00, 0, 0, t);
    waitn(2);
    rst = 1'b1;
    waitn(1);
    check("rstw_outs", {oDC_En, oIC_En, oRAM_Wr, oDC_Dat, oIC_Dat, oRAM_Dat, oRAM_Add}, 0);
    rst = 1'b0;
    waitn(5);
    check("rstw_nodone", dc_t.size(), 0);
    clear_q();
    strobe(1, 0, 18'h777, 8'h00, 0, 0, t);
    waitn(4);
    check("rstw_n", dc_t.size(), 1);
    check("rstw_t", dc_t[0], t + 3);
    check("rstw_d", dc_d[0], ref_rd(32'h777));
    dc_last = ref_rd(32'h777);
    // randomized transactions against the reference memory
    for (int i = 0; i < 150; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      dc = (kind != 2);
      ic = (kind >= 2);
      rw = 1'($urandom_range(0, 1));
      da = 18'($urandom);
      ia = 18'($urandom);
      dd = 8'($urandom);
      if ($urandom_range(0, 3) == 0) ia = da;
      clear_q();
      nw0 = n_wr;
      strobe(dc, rw, da, dd, ic, ia, t);
      waitn(8);
      check("rnd_dc_n", dc_t.size(), dc ? 1 : 0);
      check("rnd_ic_n", ic_t.size(), ic ? 1 : 0);
      check("rnd_wr_n", n_wr - nw0, (dc && rw) ? 1 : 0);
      if (dc) begin
        exp_d = rw ? dc_last : ref_rd(int'(da));
        if (rw) ref_mem[int'(da)] = dd;
        check("rnd_dc_t", dc_t[0], t + 3);
        check("rnd_dc_d", dc_d[0], exp_d);
        dc_last = exp_d;
      end
      if (ic) begin
        check("rnd_ic_t", ic_t[0], t + (dc ? 6 : 3));
        check("rnd_ic_d", ic_d[0], ref_rd(int'(ia)));
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller sitting between the cache pair (instruction cache, data cache) and the single-port byte-wide RAM/IO bus.
- Accepts one-byte request strobes from each cache, arbitrates with data cache (DC) priority, and drives the RAM.
- Returns a one-cycle completion pulse per byte, with read data.
- It is the responder to the cache-side per-byte request protocol.

Parameters:
- IO_TAG, 2'b11, value of address bits [17:16] that selects the memory-mapped IO region.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  global ready; when 0, all state holds
- iDC_En  in  1  DC byte-request strobe, one cycle
- iDC_Rw  in  1  0: read, 1: write
- iDC_Add  in  MEM_ADD_W  DC byte address
- iDC_Dat  in  MEM_DAT_W  DC write byte
- oDC_En  out  1  DC byte done pulse
- oDC_Dat  out  MEM_DAT_W  DC read byte, valid while oDC_En=1
- iIC_En  in  1  IC byte-read strobe, one cycle
- iIC_Add  in  MEM_ADD_W  IC byte address
- oIC_En  out  1  IC byte done pulse
- oIC_Dat  out  MEM_DAT_W  IC read byte
- iIO_Full  in  1  IO buffer full; blocks IO-region writes
- iRAM_Dat  in  MEM_DAT_W  RAM read data, valid one cycle after address
- oRAM_Dat  out  MEM_DAT_W  RAM write data
- oRAM_Add  out  MEM_ADD_W  RAM address
- oRAM_Wr  out  1  1 = write this cycle

Behaviour:
- Interface rules: one clock (clk), synchronous active-high reset (rst).
- Reset: all registers cleared.
  - oDC_En, oIC_En, oRAM_Wr = 0.
  - oDC_Dat, oIC_Dat, oRAM_Dat, oRAM_Add = 0.
  - Both pending slots empty; state IDLE.
  - Reset mid-transaction abandons it; no done pulse is issued.
- en=0:
  - No register updates; the request strobes present in that cycle are lost.
  - oRAM_Wr is forced to 0 combinationally so that a frozen write never repeats.
- Pending slots: one per port. The DC slot holds {valid, rw, add, dat}; the IC slot holds {valid, add}.
  - A strobe with en=1 loads the slot and sets valid, in the same edge, regardless of state.
  - A strobe while the own slot is already valid is a protocol violation: the slot is overwritten and no assertion is required.
- Done pulses default to 0 every enabled cycle.
- State machine: IDLE -> ISSUE -> WAIT -> IDLE.
  - IDLE arbitration:
    - DC slot valid and not blocked -> serve DC.
    - Otherwise IC slot valid -> serve IC.
    - Otherwise stay in IDLE.
  - Serving: latch the owner, register oRAM_Add/oRAM_Dat/oRAM_Wr from the slot, clear the slot valid bit, go to ISSUE.
  - Blocked means DC rw=1 and add[17:16]==IO_TAG and iIO_Full=1. A blocked DC slot stays pending, and the IC may be served meanwhile.
  - ISSUE: RAM address and write are presented this cycle (the write commits at the end of this cycle). Then: oRAM_Wr<=0, go to WAIT.
  - WAIT: iRAM_Dat is valid. At the end of the cycle:
    - Capture iRAM_Dat into the owner's oX_Dat.
    - Pulse the owner's oX_En for the next cycle.
    - Return to IDLE.
    - For writes, oDC_Dat is left unchanged.
- Latency:
  - A strobe at cycle t into an idle controller with no competitor gives the RAM address at t+1, data sampled at t+2, and oX_En=1 at t+3.
  - IDLE at t+3 may already start the next pending request, so back-to-back bytes take 3 cycles each.
- A strobe arriving in the same cycle the controller is in IDLE is not arbitrated until the next cycle, because slots are registered.
- The IC and DC strobing in the same cycle: DC is served first; IC starts 3 cycles later.
- Address passes through unmodified, full MEM_ADD_W.

Decomposition:
- header.vh gains:
  - state encodings MC_IDLE, MC_ISSUE, MC_WAIT (2 bits);
  - IO tag constant.
- It reuses MEM_ADD_W and MEM_DAT_W.
- One natural sub-module, mc_req_slot: a strobe-loaded {valid, rw, add, dat} register with clear. It is instantiated twice, with the IC rw tied to 0.

Test Plan:
- DC read: RAM[0x100]=0xA5, iDC_En/Rw=0/Add=0x100 at t -> oRAM_Add=0x100 at t+1, oDC_En=1 with oDC_Dat=0xA5 at t+3 only.
- DC write: Add=0x200, Dat=0x3C -> oRAM_Wr=1 for exactly one cycle (t+1), RAM[0x200]=0x3C, oDC_En at t+3, oIC_En stays 0.
- Simultaneous strobes: DC read 0x10 and IC read 0x20 at t -> oDC_En at t+3, oIC_En at t+6 with RAM[0x20] data.
- IO blocking: iIO_Full=1, DC write to 0x30000 plus IC read 0x40 -> IC is served (oIC_En at t+3), no write is issued. Drop iIO_Full at t+5 -> oRAM_Wr=1 at t+6 or later, oDC_En 2 cycles after that.
- en freeze: drop en during ISSUE of a write for 4 cycles -> oRAM_Wr=0 while en=0, RAM written exactly once, oDC_En delayed by 4 cycles.
- Reset mid-WAIT: rst=1 for 1 cycle -> all outputs 0, no done pulse, next DC read completes normally in 3 cycles.
